// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential restoring divider.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed for a counter that holds every value 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divider_sub.sv
// Ripple-borrow subtractor: diff = a - b, bout = 1 when a < b (unsigned).
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
module seq_divider_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic br;

    // Borrow ripples from the LSB upward, one full-subtractor cell per bit.
    always_comb begin
        br   = 1'b0;
        diff = '0;
        for (int i = 0; i < W; i++) begin
            diff[i] = a[i] ^ b[i] ^ br;
            br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock on a shared subtractor.
// Latency: N+1 edges from the accepting edge to done (1 edge for a zero divisor
//          when SEQ_DIVIDER_DZ_EARLY_EN is defined). Throughput one per N+2 cycles.
// Backpressure: start is taken only while ready=1; requests at other times are dropped.
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         dz
);

    import seq_divider_pkg::*;

    localparam int CW = cnt_width(N);

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  d_reg;
    logic [N-1:0]  q_reg;
    logic [N:0]    r_reg;
    logic [CW-1:0] cnt;

    logic [N:0]    s;
    logic [N:0]    t;
    logic          bout;
    logic [N-1:0]  q_nxt;
    logic [N:0]    r_nxt;
    logic          last_step;
    logic          zero_div;

    // Shift the next dividend bit into the partial remainder and trial-subtract D.
    assign s = {r_reg[N-1:0], q_reg[N-1]};

    seq_divider_sub #(.W(N + 1)) u_sub (
        .a    (s),
        .b    ({1'b0, d_reg}),
        .diff (t),
        .bout (bout)
    );

    // No borrow means S >= D: keep the difference and emit a 1 quotient bit.
    assign r_nxt     = bout ? s : t;
    assign q_nxt     = {q_reg[N-2:0], ~bout};
    assign last_step = (cnt == CW'(1));

`ifdef SEQ_DIVIDER_DZ_EARLY_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    // The partial remainder stays below D, so its top bit is always zero and
    // never needs to reach an output.
    logic unused;
    assign unused = r_reg[N];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status decode; ready/done come from the state register only.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = zero_div ? DONE : RUN;
            end
            RUN: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration registers and held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d_reg <= divisor;
                        q_reg <= dividend;
                        r_reg <= '0;
                        cnt   <= CW'(N);
                        if (zero_div) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                RUN: begin
                    r_reg <= r_nxt;
                    q_reg <= q_nxt;
                    cnt   <= cnt - CW'(1);
                    if (last_step) begin
                        quotient  <= q_nxt;
                        remainder <= r_nxt[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_DIVIDER_DZ_EARLY_EN
    logic dz_reg;

    // Divide-by-zero flag, updated only on result edges alongside quotient/remainder.
    always_ff @(posedge clk) begin
        if (rst) begin
            dz_reg <= 1'b0;
        end else if (state == IDLE && start) begin
            if (zero_div) dz_reg <= 1'b1;
        end else if (state == RUN && last_step) begin
            dz_reg <= 1'b0;
        end
    end

    assign dz = dz_reg;
`else
    assign dz = 1'b0;
`endif

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider that sequences a single shared ripple-borrow subtractor, producing one quotient bit per clock. It sits beside the combinational arithmetic blocks and serves datapaths that need division without an N-deep combinational array. Operands are taken with a start/ready handshake. Results are reported with a one-cycle done pulse and then held.

## Interface
- N, default 8: operand, quotient and remainder width; legal range N ≥ 2.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in a cycle where ready=1.
- dividend  in  N  sampled on the accepting edge.
- divisor  in  N  sampled on the accepting edge.
- ready  out  1  high only in state IDLE.
- done  out  1  one-cycle pulse; quotient and remainder are valid in this cycle.
- quotient  out  N  registered; held until the next accepted start.
- remainder  out  N  registered; held until the next accepted start.
- dz  out  1  divide-by-zero flag; registered alongside the results.

## Operation
- States:
  - IDLE: ready=1.
  - RUN: computing.
  - DONE: done=1, ready=0.
- IDLE→RUN on start=1:
  - Latch divisor into D.
  - Load the shift register Q with the dividend.
  - Clear the partial remainder R (N+1 bits).
  - Set the bit counter to N.
- RUN, each cycle:
  - S = {R[N-1:0], Q[N-1]}.
  - T = S − {1'b0, D}, computed (N+1 bits wide) by the subtractor.
  - If borrow-out = 0: R ← T and Q ← {Q[N-2:0], 1}.
  - Otherwise: R ← S and Q ← {Q[N-2:0], 0}.
  - Decrement the counter.
- RUN→DONE when the counter reaches 0 after the final step. On that edge, quotient ← Q and remainder ← R[N-1:0].
- DONE→IDLE unconditionally on the next edge.
- start during RUN or DONE is ignored; nothing is queued.
- divisor = 0 without early termination: the algorithm naturally yields quotient = 2^N−1 and remainder = dividend.
- The R top bit is always 0 after each step, since R < D ≤ 2^N−1.
- Reset:
  - Effects: state=IDLE, quotient=0, remainder=0, dz=0, done=0, ready=1 after release.
  - Reset mid-operation abandons the division; no done pulse is produced.

## Timing
- Start accepted at edge E0. The RUN steps occur at edges E1…EN. Results and the DONE state register at EN, so done is high in the cycle after EN.
- The state returns to IDLE at EN+1. Latency from acceptance to done is N+1 edges (9 for N=8).
- A new start may be accepted at the first edge where ready=1, i.e. EN+2. Throughput is one division per N+2 cycles.
- quotient, remainder and dz update only on a result edge. They are stable at all other times, including while the next division runs.
- ready is decoded from the state register and is not combinational from start.

## Configuration
- SEQ_DIVIDER_DZ_EARLY_EN.
- Defined:
  - On the accepting edge, divisor = 0 transitions IDLE→DONE directly.
  - Results: quotient = 2^N−1, remainder = dividend, dz = 1.
  - Latency is 1 edge (done in the cycle after E0).
  - dz = 0 for every nonzero divisor.
- Undefined:
  - dz is tied to 0.
  - Zero divisors run the full N steps with identical quotient and remainder values.

## Structure
- Package seq_divider_pkg:
  - State enum IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Width helper for the counter: $clog2(N+1) bits.
- One sub-module: the codebase's ripple-borrow subtractor, instantiated once with width N+1.
  - Inputs: a=S, b={0,D}.
  - Outputs: diff=T; bout drives the restore decision.
- The FSM, counter and shift registers live in seq_divider.

## Test plan
- N=8, dividend=100, divisor=7, start pulse → done exactly 9 edges after acceptance; quotient=14, remainder=2, dz=0.
- 255/1 → quotient=255, remainder=0. 5/9 → quotient=0, remainder=5. 9/9 → quotient=1, remainder=0.
- 200/0 → quotient=255, remainder=200.
  - With SEQ_DIVIDER_DZ_EARLY_EN: dz=1, done 1 edge after acceptance.
  - Without it: dz=0, done after 9 edges.
- Hold start=1 continuously:
  - Divisions are accepted only at E0, E10, E20…
  - Operand changes during RUN do not affect results.
  - Results are held between done pulses.
- Assert rst for one cycle at step 4 of 100/7:
  - No done pulse; quotient=0, remainder=0, ready=1.
  - A subsequent 50/3 returns quotient=16, remainder=2.
- Random sweep (N=8, 10k pairs, nonzero divisor) vs. the reference model: dividend = quotient·divisor + remainder, remainder < divisor.
